// File: rtl/fb_pkg.sv
// Shared types and geometry for the framebuffer port arbiter.
package fb_pkg;

    localparam int FB_W       = 320;
    localparam int FB_H       = 240;
    localparam int NUM_PIXELS = FB_W * FB_H;
    localparam int ADDR_W     = 17;
    localparam int PIX_W      = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RENDER,
        DRAIN,
        DONE
    } fb_state_t;

    // One buffered renderer write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of renderer writes with push/pop/flush.
// Push while full and pop while empty are ignored; flush wins over both.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fb_wr_t                         din,
    output fb_wr_t                         dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH+1);

    fb_wr_t             mem_q [DEPTH];
    fb_wr_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + LVL_W'(1);
                2'b01:   cnt_d = cnt_q - LVL_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM port owner: display reads have strict priority, renderer
// writes are buffered and drained in read-free cycles, frame progress tracked.
// Optional macro CLEAR_ON_START_EN: frame_start first sweeps the whole buffer
// with CLEAR_COLOR before renderer writes are accepted.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int               NUM_PIXELS  = fb_pkg::NUM_PIXELS,
    parameter int               ADDR_W      = fb_pkg::ADDR_W,
    parameter int               PIX_W       = fb_pkg::PIX_W,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               RD_LAT      = 1,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = 12'h000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic                                disp_req,
    input  logic [ADDR_W-1:0]                   disp_addr,
    output logic [PIX_W-1:0]                    disp_data,
    output logic                                disp_data_vld,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [PIX_W-1:0]                    wr_data,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [PIX_W-1:0]                    mem_din,
    input  logic [PIX_W-1:0]                    mem_dout,
    output logic                                frame_done,
    output logic                                addr_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

    localparam int                LVL_W     = $clog2(FIFO_DEPTH+1);
    localparam int                CNT_W     = $clog2(NUM_PIXELS+1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS-1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_PIXELS-1);
`ifdef CLEAR_ON_START_EN
    localparam fb_state_t         START_ST  = CLEAR;
`else
    localparam fb_state_t         START_ST  = RENDER;
`endif

    fb_state_t          state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               addr_err_q, addr_err_d;
    logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
`ifdef CLEAR_ON_START_EN
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               clr_we;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_lvl;
    fb_wr_t             fifo_din;
    fb_wr_t             fifo_head;
    logic               wr_accept;
    logic               in_range;

    assign fifo_din.addr = wr_addr;
    assign fifo_din.data = wr_data;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

    assign disp_data     = mem_dout;
    assign disp_data_vld = rd_pipe_q[RD_LAT-1];
    assign frame_done    = (state_q == DONE);
    assign addr_err      = addr_err_q;
    assign fifo_level    = fifo_lvl;

    // Handshake, port arbitration, frame accounting and next state.
    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        addr_err_d = addr_err_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = disp_addr;
        mem_din    = CLEAR_COLOR;   // idle data bus parks at the clear colour
`ifdef CLEAR_ON_START_EN
        clr_cnt_d  = clr_cnt_q;
        clr_we     = 1'b0;
`endif

        // frame_start blocks the handshake so a restart never races a write.
        wr_ready  = (state_q == RENDER) && !fifo_full && !frame_start;
        wr_accept = wr_valid && wr_ready;
        in_range  = (wr_addr <= LAST_ADDR);

        // Reads own the port; writes (clear or buffered) only in read-free
        // cycles, and none on a restart cycle since pending writes are dropped.
        if (!disp_req && !frame_start) begin
`ifdef CLEAR_ON_START_EN
            if (state_q == CLEAR) begin
                clr_we   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
                mem_din  = CLEAR_COLOR;
            end else
`endif
            if (!fifo_empty) begin
                mem_we   = 1'b1;
                mem_addr = fifo_head.addr;
                mem_din  = fifo_head.data;
                fifo_pop = 1'b1;
            end
        end

        // Out-of-range writes are consumed but only flagged.
        if (wr_accept) begin
            if (in_range) begin
                fifo_push = 1'b1;
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end else begin
                addr_err_d = 1'b1;
            end
        end

        if (frame_start) begin
            state_d    = START_ST;
            acc_cnt_d  = '0;
            addr_err_d = 1'b0;
            fifo_flush = 1'b1;
`ifdef CLEAR_ON_START_EN
            clr_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                RENDER: begin
                    if (fifo_push && (acc_cnt_q == LAST_CNT)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_pop && (fifo_lvl == LVL_W'(1))) begin
                        state_d = DONE;
                    end
                end
`ifdef CLEAR_ON_START_EN
                CLEAR: begin
                    if (clr_we) begin
                        if (clr_cnt_q == LAST_ADDR) begin
                            clr_cnt_d = '0;
                            state_d   = RENDER;
                        end else begin
                            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Read-valid delay line matching the BRAM read latency.
    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = disp_req;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_cnt_q  <= '0;
            addr_err_q <= 1'b0;
            rd_pipe_q  <= '0;
`ifdef CLEAR_ON_START_EN
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            addr_err_q <= addr_err_d;
            rd_pipe_q  <= rd_pipe_d;
`ifdef CLEAR_ON_START_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

endmodule
